// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: opcodes, FSM state encoding and default geometry shared by vector_alu_seq.
package vector_alu_pkg;
  localparam int DEF_LANE_W = 32;
  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_LPC = 4;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_AND = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE} state_t;
endpackage

// File: rtl/vector_alu_lane.sv
// vector_alu_lane: one signed lane, x op y -> 2*LANE_W result; o_ovf present when VALU_OVF_FLAG_EN is defined.
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0]   i_x,
  input  logic [LANE_W-1:0]   i_y,
  input  logic [1:0]          i_op,
  output logic [2*LANE_W-1:0] o_res
`ifdef VALU_OVF_FLAG_EN
  ,
  output logic                o_ovf
`endif
);
  logic [2*LANE_W-1:0] w_x, w_y;
  assign w_x = {{LANE_W{i_x[LANE_W-1]}}, i_x};
  assign w_y = {{LANE_W{i_y[LANE_W-1]}}, i_y};
  // Low 2W bits of the product of sign-extended operands equal the signed W x W product.
  assign o_res = (i_op == OP_ADD) ? w_x + w_y :
                 (i_op == OP_SUB) ? w_x - w_y :
                 (i_op == OP_MUL) ? w_x * w_y :
                 {{LANE_W{1'b0}}, i_x & i_y};
`ifdef VALU_OVF_FLAG_EN
  assign o_ovf = !i_op[1] && (o_res[2*LANE_W-1:LANE_W] != {LANE_W{o_res[LANE_W-1]}});
`endif
endmodule

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: multi-cycle vector ALU, LANES_PER_CYCLE lanes per EXEC cycle, one write strobe per op.
// Defining VALU_OVF_FLAG_EN adds the per-lane signed-overflow output ovf_lanes.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int LANE_W          = DEF_LANE_W,
  parameter int NUM_LANES       = DEF_NUM_LANES,
  parameter int LANES_PER_CYCLE = DEF_LPC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [LANE_W*NUM_LANES-1:0] A1,
  input  logic [LANE_W*NUM_LANES-1:0] A2,
  output logic                        busy,
  output logic                        done,
  output logic                        write_enable_alu,
  output logic [LANE_W*NUM_LANES-1:0] alu_data_A3,
  output logic [LANE_W*NUM_LANES-1:0] alu_data_A4
`ifdef VALU_OVF_FLAG_EN
  ,
  output logic [NUM_LANES-1:0]        ovf_lanes
`endif
);
  localparam int CHUNKS = NUM_LANES / LANES_PER_CYCLE;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_t r_state, w_next;
  logic [CW-1:0] r_chunk;
  logic [1:0] r_op;
  logic [NUM_LANES-1:0][LANE_W-1:0] r_a1, r_a2, r_lo, r_hi;
  logic [LANES_PER_CYCLE-1:0][IW-1:0] w_idx;
  logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] w_x, w_y;
  logic [LANES_PER_CYCLE-1:0][2*LANE_W-1:0] w_res;
  logic w_last;
`ifdef VALU_OVF_FLAG_EN
  logic [NUM_LANES-1:0] r_ovf;
  logic [LANES_PER_CYCLE-1:0] w_ovf;
  assign ovf_lanes = r_ovf;
`endif

  assign w_last = r_chunk == CW'(CHUNKS - 1);
  assign alu_data_A3 = r_lo;
  assign alu_data_A4 = r_hi;

  genvar j;
  generate
    for (j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
      assign w_idx[j] = IW'(r_chunk * LANES_PER_CYCLE + j);
      assign w_x[j] = r_a1[w_idx[j]];
      assign w_y[j] = r_a2[w_idx[j]];
      vector_alu_lane #(.LANE_W(LANE_W)) u_lane (
        .i_x  (w_x[j]),
        .i_y  (w_y[j]),
        .i_op (r_op),
        .o_res(w_res[j])
`ifdef VALU_OVF_FLAG_EN
        ,
        .o_ovf(w_ovf[j])
`endif
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = (r_state == S_IDLE) ? (start ? S_EXEC : S_IDLE) :
             (r_state == S_EXEC) ? (w_last ? S_WRITE : S_EXEC) : S_IDLE;
    busy = r_state != S_IDLE;
    done = r_state == S_WRITE;
    write_enable_alu = r_state == S_WRITE;
  end

  // Results land directly in the output registers; downstream only samples at the strobe.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_chunk <= '0;
      r_op <= OP_ADD;
      r_a1 <= '0;
      r_a2 <= '0;
      r_lo <= '0;
      r_hi <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_chunk <= '0;
      r_op <= op;
      r_a1 <= A1;
      r_a2 <= A2;
    end else if (r_state == S_EXEC) begin
      r_chunk <= r_chunk + 1'b1;
      for (int k = 0; k < LANES_PER_CYCLE; k++) begin
        r_lo[w_idx[k]] <= w_res[k][LANE_W-1:0];
        r_hi[w_idx[k]] <= w_res[k][2*LANE_W-1:LANE_W];
      end
    end

`ifdef VALU_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ovf <= '0;
    else if (r_state == S_EXEC)
      for (int k = 0; k < LANES_PER_CYCLE; k++) r_ovf[w_idx[k]] <= w_ovf[k];
`endif
endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: scoreboard bench for vector_alu_seq; checks ovf_lanes when VALU_OVF_FLAG_EN is defined.
module tb_vector_alu_seq;
  logic clk = 0, rst_n = 1, start = 0;
  logic [1:0] op = 0;
  logic [511:0] A1 = '0, A2 = '0;
  logic busy, done, we;
  logic [511:0] A3, A4;
`ifdef VALU_OVF_FLAG_EN
  logic [15:0] ovf_lanes;
`endif

  typedef struct {logic [511:0] a3; logic [511:0] a4; logic [15:0] ovf;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  vector_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A1(A1), .A2(A2),
    .busy(busy), .done(done), .write_enable_alu(we), .alu_data_A3(A3), .alu_data_A4(A4)
`ifdef VALU_OVF_FLAG_EN
    , .ovf_lanes(ovf_lanes)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [1:0] o, logic [511:0] x, logic [511:0] y);
    exp_t e;
    longint a, b, r;
    for (int i = 0; i < 16; i++) begin
      a = longint'($signed(x[i*32 +: 32]));
      b = longint'($signed(y[i*32 +: 32]));
      r = (o == 2'b00) ? a + b : (o == 2'b01) ? a - b : (o == 2'b10) ? a * b :
          longint'({32'b0, x[i*32 +: 32] & y[i*32 +: 32]});
      e.a3[i*32 +: 32] = r[31:0];
      e.a4[i*32 +: 32] = r[63:32];
      e.ovf[i] = (o < 2'b10) && (r > 64'sd2147483647 || r < -64'sd2147483648);
    end
    return e;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [511:0] x, input logic [511:0] y);
    @(negedge clk);
    start = 1; op = o; A1 = x; A2 = y;
    sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!we && cyc < 20);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0 || we !== 1'b0) begin n_err++; $display("FAIL reset_done_we got %b%b want 00", done, we); end
    n_vec++; if (A3 !== '0 || A4 !== '0) begin n_err++; $display("FAIL reset_data got %h / %h want 0", A3, A4); end
`ifdef VALU_OVF_FLAG_EN
    n_vec++; if (ovf_lanes !== '0) begin n_err++; $display("FAIL reset_ovf got %h want 0", ovf_lanes); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_arith();
    logic [1:0] ops[6];
    logic [511:0] xs[6], ys[6];
    exp_t e;
    int cyc;
    ops[0] = 2'b00; xs[0] = {16{32'h7FFFFFFF}}; ys[0] = {16{32'h00000001}};
    ops[1] = 2'b01; xs[1] = '0; ys[1] = {16{32'h00000001}};
    ops[2] = 2'b10; xs[2] = rnd512(); ys[2] = rnd512();
    xs[2][31:0] = 32'hFFFFFFFE; ys[2][31:0] = 32'd3;
    xs[2][511:480] = 32'h7FFFFFFF; ys[2][511:480] = 32'h7FFFFFFF;
    ops[3] = 2'b11; xs[3] = rnd512(); ys[3] = rnd512();
    ops[4] = 2'b00; xs[4] = rnd512(); ys[4] = rnd512();
    ops[5] = 2'b01; xs[5] = rnd512(); ys[5] = rnd512();
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_strobe(cyc);
      n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL latency op%0d got %0d want 4", i, cyc); end
      n_vec++; if (done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL done_busy op%0d got %b%b want 11", i, done, busy); end
      e = sb.pop_front();
      n_vec++; if (A3 !== e.a3) begin n_err++; $display("FAIL A3 op%0d got %h want %h", i, A3, e.a3); end
      n_vec++; if (A4 !== e.a4) begin n_err++; $display("FAIL A4 op%0d got %h want %h", i, A4, e.a4); end
`ifdef VALU_OVF_FLAG_EN
      n_vec++; if (ovf_lanes !== e.ovf) begin n_err++; $display("FAIL ovf op%0d got %h want %h", i, ovf_lanes, e.ovf); end
`endif
      if (i == 2) begin
        n_vec++; if ({A4[31:0], A3[31:0]} !== 64'hFFFFFFFF_FFFFFFFA) begin n_err++; $display("FAIL mul_lane0 got %h want FFFFFFFFFFFFFFFA", {A4[31:0], A3[31:0]}); end
        n_vec++; if ({A4[511:480], A3[511:480]} !== 64'h3FFFFFFF_00000001) begin n_err++; $display("FAIL mul_lane15 got %h want 3FFFFFFF00000001", {A4[511:480], A3[511:480]}); end
      end
      @(negedge clk);
      n_vec++; if (we !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL strobe_width op%0d got we=%b busy=%b want 00", i, we, busy); end
    end
  endtask

  task automatic test_capture();
    int busy_cnt = 0, we_cnt = 0;
    exp_t e;
    issue(2'b00, rnd512(), rnd512());
    for (int k = 0; k < 16; k++) begin
      if (busy) busy_cnt++;
      if (we) begin
        we_cnt++;
        e = sb.pop_front();
        n_vec++; if (A3 !== e.a3 || A4 !== e.a4) begin n_err++; $display("FAIL capture_data got %h_%h want %h_%h", A4, A3, e.a4, e.a3); end
      end
      start = (k == 1);
      if (k == 1) begin A1 = rnd512(); A2 = rnd512(); end
      @(negedge clk);
    end
    n_vec++; if (busy_cnt !== 5) begin n_err++; $display("FAIL capture_busy_cycles got %0d want 5", busy_cnt); end
    n_vec++; if (we_cnt !== 1) begin n_err++; $display("FAIL capture_strobes got %0d want 1", we_cnt); end
  endtask

  task automatic test_reset_abort();
    int we_cnt = 0;
    issue(2'b10, rnd512(), rnd512());
    @(negedge clk);
    rst_n = 0;
    #1;
    void'(sb.pop_back());
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin n_err++; $display("FAIL abort_ctrl got busy=%b done=%b we=%b want 000", busy, done, we); end
    n_vec++; if (A3 !== '0 || A4 !== '0) begin n_err++; $display("FAIL abort_data got %h / %h want 0", A3, A4); end
`ifdef VALU_OVF_FLAG_EN
    n_vec++; if (ovf_lanes !== '0) begin n_err++; $display("FAIL abort_ovf got %h want 0", ovf_lanes); end
`endif
    @(negedge clk);
    rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      if (we) we_cnt++;
    end
    n_vec++; if (we_cnt !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_after got strobes=%0d busy=%b want 0 0", we_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] x = rnd512(), y = rnd512();
    int last_k = -1, cnt = 0, late = 0;
    logic prev_done = 0;
    exp_t e;
    @(negedge clk);
    start = 1; op = 2'b10; A1 = x; A2 = y;
    repeat (5) sb.push_back(model(2'b10, x, y));
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_vec++; if (prev_done && done) begin n_err++; $display("FAIL b2b_done_twice at %0d got 1 want 0", k); end
      prev_done = done;
      if (we) begin
        if (last_k >= 0) begin
          n_vec++; if (k - last_k !== 6) begin n_err++; $display("FAIL b2b_interval got %0d want 6", k - last_k); end
        end
        last_k = k;
        cnt++;
        if (sb.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_extra_strobe at %0d got strobe want none", k);
        end else begin
          e = sb.pop_front();
          n_vec++; if (A3 !== e.a3 || A4 !== e.a4) begin n_err++; $display("FAIL b2b_data got %h_%h want %h_%h", A4, A3, e.a4, e.a3); end
        end
      end
    end
    start = 0;
    repeat (12) begin
      @(negedge clk);
      if (we) late++;
    end
    n_vec++; if (cnt !== 5) begin n_err++; $display("FAIL b2b_strobes got %0d want 5", cnt); end
    n_vec++; if (late !== 0 || sb.size() !== 0) begin n_err++; $display("FAIL b2b_drain got late=%0d left=%0d want 0 0", late, sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_capture();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
